uart_baud_gen: RTL and testbench

Programmable fractional baud-rate tick generator for the UART top module. It is the successor to the fixed-terminal timer. It produces a one-cycle oversample tick (tick_os) for the RX sampler and a one-cycle bit tick (tick_bit) for the TX shifter. The divisor is loadable at run time and has a fractional part, so standard baud rates can be generated from any system clock with bounded jitter (at most one clock cycle per oversample period).

---
 rtl/uart_baud_if.sv | 26 ++
 rtl/uart_baud_gen.sv | 102 ++++++++++
 tb/tb_uart_baud_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_if.sv
// uart_baud_if: control and tick bundle between the UART top and the baud generator.
//   master : UART top; drives enable/load/div_int/div_frac/sync_clr, receives ticks
//   slave  : uart_baud_gen; receives controls, drives tick_os/tick_bit/div_zero
interface uart_baud_if #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned FRAC_BITS = 4
);
    logic                 enable;
    logic                 load;
    logic [DIV_WIDTH-1:0] div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic                 sync_clr;
    logic                 tick_os;
    logic                 tick_bit;
    logic                 div_zero;

    modport master (
        output enable, load, div_int, div_frac, sync_clr,
        input  tick_os, tick_bit, div_zero
    );

    modport slave (
        input  enable, load, div_int, div_frac, sync_clr,
        output tick_os, tick_bit, div_zero
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable fractional baud tick generator.
// Each oversample period lasts div_int or div_int+1 enabled cycles, chosen by a
// fractional accumulator so the long-run period is div_int + div_frac/2^FRAC_BITS.
//   clk, reset_n      : clock, synchronous active-low reset
//   bus.enable        : count enable (counters hold when low)
//   bus.load          : latch div_int/div_frac and restart counters
//   bus.sync_clr      : restart counters, keep divisor
//   bus.tick_os       : one-cycle oversample tick
//   bus.tick_bit      : one-cycle bit tick, every OVERSAMPLE-th tick_os
//   bus.div_zero      : latched integer divisor is zero, generator stalled
module uart_baud_gen #(
    parameter int unsigned DIV_WIDTH        = 16,
    parameter int unsigned FRAC_BITS        = 4,
    parameter int unsigned OVERSAMPLE       = 16,
    parameter int unsigned DEFAULT_DIV_INT  = 325,
    parameter int unsigned DEFAULT_DIV_FRAC = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    uart_baud_if.slave bus
);
    localparam int unsigned OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned CMP_W = DIV_WIDTH + 1;

    logic [DIV_WIDTH-1:0] div_int_r;
    logic [FRAC_BITS-1:0] div_frac_r;
    logic [DIV_WIDTH-1:0] cnt;
    logic [FRAC_BITS-1:0] frac_acc;
    logic [OS_W-1:0]      os_cnt;
    logic                 tick_os;
    logic                 tick_bit;
    logic                 div_zero;

    logic [FRAC_BITS:0]   sum_c;
    logic                 carry_c;
    logic [CMP_W-1:0]     term_c;
    logic                 at_term_c;
    logic                 os_last_c;

    // Terminal count for the current period; one bit wider so div_int=max plus carry fits.
    always_comb begin
        sum_c     = {1'b0, frac_acc} + {1'b0, div_frac_r};
        carry_c   = sum_c[FRAC_BITS];
        term_c    = {1'b0, div_int_r} + CMP_W'(carry_c);
        at_term_c = (({1'b0, cnt} + CMP_W'(1)) == term_c);
        os_last_c = (os_cnt == OS_W'(OVERSAMPLE - 1));
    end

    // Divisor latch, period counter, fractional accumulator and oversample counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_int_r  <= DIV_WIDTH'(DEFAULT_DIV_INT);
            div_frac_r <= FRAC_BITS'(DEFAULT_DIV_FRAC);
            div_zero   <= (DEFAULT_DIV_INT == 0);
            cnt        <= '0;
            frac_acc   <= '0;
            os_cnt     <= '0;
            tick_os    <= 1'b0;
            tick_bit   <= 1'b0;
        end else if (bus.load) begin
            div_int_r  <= bus.div_int;
            div_frac_r <= bus.div_frac;
            div_zero   <= (bus.div_int == '0);
            cnt        <= '0;
            frac_acc   <= '0;
            os_cnt     <= '0;
            tick_os    <= 1'b0;
            tick_bit   <= 1'b0;
        end else if (bus.sync_clr) begin
            cnt        <= '0;
            frac_acc   <= '0;
            os_cnt     <= '0;
            tick_os    <= 1'b0;
            tick_bit   <= 1'b0;
        end else if (bus.enable && !div_zero) begin
            if (at_term_c) begin
                cnt      <= '0;
                frac_acc <= sum_c[FRAC_BITS-1:0];
                tick_os  <= 1'b1;
                if (os_last_c) begin
                    os_cnt   <= '0;
                    tick_bit <= 1'b1;
                end else begin
                    os_cnt   <= os_cnt + OS_W'(1);
                    tick_bit <= 1'b0;
                end
            end else begin
                cnt      <= cnt + DIV_WIDTH'(1);
                tick_os  <= 1'b0;
                tick_bit <= 1'b0;
            end
        end else begin
            // Disabled or stalled on a zero divisor: hold counters, no ticks.
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
        end
    end

    assign bus.tick_os  = tick_os;
    assign bus.tick_bit = tick_bit;
    assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: randomized and directed bench for uart_baud_gen with an
// arithmetic reference model (tick k falls on enabled edge k*D + floor(k*f/16)).
module tb_uart_baud_gen;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = 4;
    localparam int unsigned OS = 16;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    uart_baud_if #(.DIV_WIDTH(DW), .FRAC_BITS(FW)) bus ();

    uart_baud_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts enabled edges since restart and the ticks emitted.
    longint m_d;
    longint m_f;
    longint m_n;
    longint m_k;
    bit     m_on;
    bit     e_os;
    bit     e_bit;
    bit     e_dz;

    initial begin
        m_on = 1'b0;
        e_os = 1'b0;
        e_bit = 1'b0;
        e_dz = 1'b0;
    end

    always @(posedge clk) begin
        longint nxt;
        if (!reset_n) begin
            m_d = 325; m_f = 8; m_n = 0; m_k = 0;
            e_os = 1'b0; e_bit = 1'b0; m_on = 1'b1;
        end else if (bus.load) begin
            m_d = longint'(bus.div_int); m_f = longint'(bus.div_frac);
            m_n = 0; m_k = 0; e_os = 1'b0; e_bit = 1'b0;
        end else if (bus.sync_clr) begin
            m_n = 0; m_k = 0; e_os = 1'b0; e_bit = 1'b0;
        end else if (bus.enable && m_d != 0) begin
            m_n = m_n + 1;
            nxt = (m_k + 1) * m_d + (((m_k + 1) * m_f) / (1 << FW));
            if (m_n == nxt) begin
                m_k   = m_k + 1;
                e_os  = 1'b1;
                e_bit = ((m_k % OS) == 0);
            end else begin
                e_os = 1'b0; e_bit = 1'b0;
            end
        end else begin
            e_os = 1'b0; e_bit = 1'b0;
        end
        e_dz = (m_d == 0);
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            n_cmp += 3;
            if (bus.tick_os !== e_os) begin
                n_err++;
                $display("FAIL tick_os @%0t: got %b want %b", $time, bus.tick_os, e_os);
            end
            if (bus.tick_bit !== e_bit) begin
                n_err++;
                $display("FAIL tick_bit @%0t: got %b want %b", $time, bus.tick_bit, e_bit);
            end
            if (bus.div_zero !== e_dz) begin
                n_err++;
                $display("FAIL div_zero @%0t: got %b want %b", $time, bus.div_zero, e_dz);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic do_load(input int di, input int df);
        @(negedge clk);
        bus.load = 1'b1; bus.div_int = DW'(di); bus.div_frac = FW'(df);
        @(negedge clk); bus.load = 1'b0;
    endtask

    task automatic do_sync();
        @(negedge clk); bus.sync_clr = 1'b1;
        @(negedge clk); bus.sync_clr = 1'b0;
    endtask

    // Count negedges until the chosen tick is seen and compare with a literal.
    task automatic expect_after(input string name, input bit use_bit, input int want, input int bound);
        int c;
        bit seen;
        c = 0; seen = 1'b0;
        while (!seen && c < bound) begin
            @(negedge clk);
            c++;
            seen = use_bit ? bus.tick_bit : bus.tick_os;
        end
        n_cmp++;
        if (!seen || c != want) begin
            n_err++;
            $display("FAIL %s: got %0d cycles (seen=%0b) want %0d", name, c, seen, want);
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        n_cmp = 0; n_err = 0;
        reset_n = 1'b0;
        bus.enable = 1'b1; bus.load = 1'b0; bus.sync_clr = 1'b0;
        bus.div_int = '0; bus.div_frac = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Defaults: 325/8 gives periods 325, 326 and a bit tick at 5208.
        expect_bit("reset tick_os", bus.tick_os, 1'b0);
        expect_bit("reset tick_bit", bus.tick_bit, 1'b0);
        expect_bit("reset div_zero", bus.div_zero, 1'b0);
        expect_after("default os1", 1'b0, 325, 400);
        expect_after("default os2", 1'b0, 326, 400);
        do_reset();
        expect_after("default bit", 1'b1, 5208, 6000);

        // Integer divisor 4.
        do_load(4, 0);
        expect_after("div4 os1", 1'b0, 4, 10);
        expect_after("div4 os2", 1'b0, 4, 10);
        do_load(4, 0);
        expect_after("div4 bit", 1'b1, 64, 100);

        // 3 + 4/16: periods 3,3,3,4; 16 ticks in 52 cycles.
        do_load(3, 4);
        expect_after("div3.25 p1", 1'b0, 3, 10);
        expect_after("div3.25 p2", 1'b0, 3, 10);
        expect_after("div3.25 p3", 1'b0, 3, 10);
        expect_after("div3.25 p4", 1'b0, 4, 10);
        do_load(3, 4);
        expect_after("div3.25 bit", 1'b1, 52, 100);

        // Enable gap preserves the count.
        do_load(10, 0);
        repeat (5) @(negedge clk);
        bus.enable = 1'b0;
        repeat (7) @(negedge clk);
        bus.enable = 1'b1;
        expect_after("enable resume", 1'b0, 5, 20);

        // Zero divisor stalls, nonzero load recovers.
        do_load(0, 5);
        expect_bit("div0 div_zero", bus.div_zero, 1'b1);
        ticks = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tick_os || bus.tick_bit) ticks++;
        end
        n_cmp++;
        if (ticks != 0) begin
            n_err++;
            $display("FAIL div0 ticks: got %0d want 0", ticks);
        end
        do_load(2, 0);
        expect_bit("div2 div_zero", bus.div_zero, 1'b0);
        expect_after("div2 os1", 1'b0, 2, 10);
        expect_after("div2 os2", 1'b0, 2, 10);

        // sync_clr mid-period realigns phase and the oversample count.
        do_load(8, 0);
        repeat (5) @(negedge clk);
        do_sync();
        expect_after("sync os", 1'b0, 8, 20);
        expect_after("sync bit", 1'b1, 120, 200);

        // Reset mid-period restores the default divisor.
        do_load(8, 0);
        repeat (5) @(negedge clk);
        do_reset();
        expect_after("reset mid os", 1'b0, 325, 400);

        // Randomized segments checked by the model every cycle.
        for (int seg = 0; seg < 40; seg++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5)      do_load(int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
            else if (r == 6) do_sync();
            else if (r == 7) do_reset();
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                bus.enable   = ($urandom_range(0, 3) != 0);
                bus.sync_clr = ($urandom_range(0, 99) == 0);
            end
            @(negedge clk);
            bus.enable = 1'b1; bus.sync_clr = 1'b0;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
